bcd_hex_display: RTL and testbench

Sequential formatter between the binary-to-BCD converter and the board's six seven-segment displays. Latches a packed BCD word on a load strobe and scans it one digit per cycle from the most significant digit down, applying optional leading-zero blanking and flagging non-decimal nibbles. The decoded, active-low segment patterns are committed to the outputs atomically, so the displays never show a half-updated value.

---
 rtl/bcd_hex_display_if.sv | 32 +++
 rtl/bcd_hex_display.sv | 130 +++++++++++++
 tb/tb_bcd_hex_display.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_hex_display_if.sv
// Load/status/segment bundle between the BCD source, the formatter and the displays.
// The neg port exists only when BCD_DISP_SIGN_EN is defined.
interface bcd_hex_display_if #(
  parameter int DIGITS = 6
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                load;
  logic                lz_blank;
`ifdef BCD_DISP_SIGN_EN
  logic                neg;
`endif
  logic                busy;
  logic                done;
  logic                err;
  logic [7*DIGITS-1:0] hex_out;

  modport master (
    output bcd_in, load, lz_blank,
`ifdef BCD_DISP_SIGN_EN
    output neg,
`endif
    input  busy, done, err, hex_out
  );

  modport slave (
    input  bcd_in, load, lz_blank,
`ifdef BCD_DISP_SIGN_EN
    input  neg,
`endif
    output busy, done, err, hex_out
  );
endinterface

// File: rtl/bcd_hex_display.sv
// Latches a packed BCD word, scans it MSD-first into a shadow register and commits
// active-low seven-segment patterns atomically. Define BCD_DISP_SIGN_EN for a minus sign.
module bcd_hex_display #(
  parameter int DIGITS = 6
) (
  input logic               clk,
  input logic               rst_n,
  bcd_hex_display_if.slave  bus
);
  localparam int                IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  TOP_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] word_q;
  logic                lzb_q;
  logic [IDX_W-1:0]    idx_q;
  logic                seen_q;
  logic                serr_q;
  logic [7*DIGITS-1:0] shadow_q, shadow_d;
  logic [7*DIGITS-1:0] hex_q;
  logic                err_q;
  logic                done_q;

  logic [3:0]          nib;
  logic                minus, nz, blank, digit_err;
  logic [6:0]          seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h06;
    endcase
    return s;
  endfunction

  wire accept = (state_q == IDLE) && bus.load;
  wire last   = (idx_q == '0);

`ifdef BCD_DISP_SIGN_EN
  logic neg_q;
  assign minus = neg_q && (idx_q == TOP_IDX);
`else
  assign minus = 1'b0;
`endif

  // Digit decode: the minus sign overrides the nibble and hides it from blanking/err
  always_comb begin
    nib       = word_q[4*int'(idx_q) +: 4];
    nz        = (nib != 4'd0) && !minus;
    digit_err = (nib > 4'd9) && !minus;
    blank     = (nib == 4'd0) && lzb_q && !seen_q && !last;
    if (minus)      seg = 7'h3F;
    else if (blank) seg = 7'h7F;
    else            seg = seg_decode(nib);
    shadow_d = shadow_q;
    shadow_d[7*int'(idx_q) +: 7] = seg;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load) state_d = SCAN;
      SCAN:    if (last)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Input capture: only meaningful once accepted, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= bus.bcd_in;
      lzb_q  <= bus.lz_blank;
`ifdef BCD_DISP_SIGN_EN
      neg_q  <= bus.neg;
`endif
    end
  end

  // Scan and commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      seen_q   <= 1'b0;
      serr_q   <= 1'b0;
      shadow_q <= '0;
      hex_q    <= '1;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        idx_q  <= TOP_IDX;
        seen_q <= 1'b0;
        serr_q <= 1'b0;
      end else if (state_q == SCAN) begin
        shadow_q <= shadow_d;
        seen_q   <= seen_q | nz;
        serr_q   <= serr_q | digit_err;
        idx_q    <= idx_q - 1'b1;
        if (last) begin
          hex_q  <= shadow_d;
          err_q  <= serr_q | digit_err;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy    = (state_q == SCAN);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.hex_out = hex_q;
endmodule

// File: tb/tb_bcd_hex_display.sv
// Randomized bench for bcd_hex_display: timing, decode, blanking, err, load-while-busy and abort.
module tb_bcd_hex_display;
  localparam int D = 6;
  localparam logic [7*D-1:0] BLANK = '1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_hex_display_if #(.DIGITS(D)) bus();
  bcd_hex_display #(.DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7*D-1:0] prev_hex = BLANK;
  logic           prev_err = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk digits from the top, tracking whether anything nonzero was shown
  function automatic logic [7*D-1:0] model_hex(input logic [4*D-1:0] w, input bit lzb, input bit ng);
    logic [7*D-1:0] h;
    bit seen;
    int n;
    h = '0;
    seen = 0;
    for (int k = D - 1; k >= 0; k--) begin
      n = int'(w[4*k +: 4]);
      if (ng && k == D - 1)                        h[7*k +: 7] = 7'h3F;
      else if (n > 9)                              h[7*k +: 7] = 7'h06;
      else if (n == 0 && lzb && !seen && k != 0)   h[7*k +: 7] = 7'h7F;
      else                                         h[7*k +: 7] = seg_tab[n];
      if (!(ng && k == D - 1) && n != 0) seen = 1;
    end
    return h;
  endfunction

  function automatic bit model_err(input logic [4*D-1:0] w, input bit ng);
    bit e;
    e = 0;
    for (int k = 0; k < D; k++)
      if (!(ng && k == D - 1) && w[4*k +: 4] > 4'd9) e = 1;
    return e;
  endfunction

  function automatic logic [4*D-1:0] rand_word();
    logic [4*D-1:0] w;
    int lz;
    lz = int'($urandom_range(0, D));
    for (int k = 0; k < D; k++) begin
      if (k >= D - lz)                   w[4*k +: 4] = 4'd0;
      else if ($urandom_range(0, 15) < 13) w[4*k +: 4] = 4'($urandom_range(0, 9));
      else                               w[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return w;
  endfunction

  task automatic drive_inputs(input logic [4*D-1:0] w, input bit lzb, input bit ng, input bit ld);
    bus.bcd_in   = w;
    bus.lz_blank = lzb;
`ifdef BCD_DISP_SIGN_EN
    bus.neg      = ng;
`endif
    bus.load     = ld;
  endtask

  // Called at a negedge (cycle T); returns at the negedge of the done cycle T+D+1.
  task automatic scan(input logic [4*D-1:0] w, input bit lzb, input bit ng, input int ignore_at);
    logic [7*D-1:0] eh;
    bit ee;
    eh = model_hex(w, lzb, ng);
    ee = model_err(w, ng);
    drive_inputs(w, lzb, ng, 1'b1);
    @(posedge clk);
    #1;
    drive_inputs(rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 1; i <= D; i++) begin
      @(negedge clk);
      check("busy_scan", 64'(bus.busy), 64'(1));
      check("done_scan", 64'(bus.done), 64'(0));
      check("hex_hold", 64'(bus.hex_out), 64'(prev_hex));
      check("err_hold", 64'(bus.err), 64'(prev_err));
      bus.load = (i == ignore_at);
      if (i == ignore_at) bus.bcd_in = rand_word();
    end
    @(negedge clk);
    bus.load = 1'b0;
    check("done_pulse", 64'(bus.done), 64'(1));
    check("busy_done", 64'(bus.busy), 64'(0));
    check("hex_commit", 64'(bus.hex_out), 64'(eh));
    check("err_commit", 64'(bus.err), 64'(ee));
    prev_hex = eh;
    prev_err = ee;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("done_idle", 64'(bus.done), 64'(0));
      check("busy_idle", 64'(bus.busy), 64'(0));
      check("hex_idle", 64'(bus.hex_out), 64'(prev_hex));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_inputs(24'h123456, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hex", 64'(bus.hex_out), 64'(BLANK));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_err", 64'(bus.err), 64'(0));
    end
    rst_n = 1'b1;
    bus.load = 1'b0;
    idle_cycles(2);

    scan(24'h001234, 1'b1, 1'b0, 0);
    check("dir_lz", 64'(bus.hex_out), 64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
    idle_cycles(1);
    scan(24'h001234, 1'b0, 1'b0, 0);
    check("dir_nolz", 64'(bus.hex_out), 64'({7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19}));
    scan(24'h000000, 1'b1, 1'b0, 0);
    check("dir_zero", 64'(bus.hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    scan(24'h00A005, 1'b1, 1'b0, 0);
    check("dir_inv", 64'(bus.hex_out), 64'({7'h7F, 7'h7F, 7'h06, 7'h40, 7'h40, 7'h12}));
    check("dir_inv_err", 64'(bus.err), 64'(1));

    // Request at T+3 ignored, request in the done cycle accepted back to back
    scan(24'h987654, 1'b0, 1'b0, 3);
    scan(24'h000321, 1'b1, 1'b0, 0);
    idle_cycles(1);

    // Abort at T+4
    drive_inputs(24'h555555, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hex", 64'(bus.hex_out), 64'(BLANK));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_err", 64'(bus.err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    prev_hex = BLANK;
    prev_err = 1'b0;
    idle_cycles(D + 2);

`ifdef BCD_DISP_SIGN_EN
    scan(24'h000042, 1'b1, 1'b1, 0);
    check("dir_neg", 64'(bus.hex_out), 64'({7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}));
    scan(24'hF00007, 1'b1, 1'b1, 0);
    check("dir_neg_err", 64'(bus.err), 64'(0));
`endif

    for (int t = 0; t < 150; t++) begin
      bit ng;
      ng = 1'b0;
`ifdef BCD_DISP_SIGN_EN
      ng = 1'($urandom_range(0, 1));
`endif
      scan(rand_word(), 1'($urandom_range(0, 1)), ng,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D - 1)) : 0);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
